// File: rtl/h264_quantize_param_if.sv
// ---------------------------------------------------------------------------
// h264_quantize_param_if
//
// Sample and level bus of the H.264 forward quantiser.
//
//   master (coefficient source / level sink):
//     drives   ENABLE, DCCI, INTRA, QP, YNIN
//     receives VALID, DCCO, ZOUT, NZCOUNT, BLKDONE
//   slave (quantiser): the mirror image.
//
//   ENABLE   sample on YNIN is valid this cycle
//   DCCI     sample is a DC coefficient
//   INTRA    rounding mode for this sample (1 = intra, 0 = inter)
//   QP       quantiser parameter 0..51 for this sample
//   YNIN     signed transform coefficient
//   VALID    ZOUT carries a level this cycle
//   DCCO     ZOUT is a DC level
//   ZOUT     signed quantised level
//   NZCOUNT  non-zero AC levels of the completed block, valid with BLKDONE
//   BLKDONE  one-cycle pulse with the last AC level of a block
// ---------------------------------------------------------------------------
interface h264_quantize_param_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 12
) ();

    logic                    ENABLE;
    logic                    DCCI;
    logic                    INTRA;
    logic [5:0]              QP;
    logic signed [IN_W-1:0]  YNIN;

    logic                    VALID;
    logic                    DCCO;
    logic signed [OUT_W-1:0] ZOUT;
    logic [4:0]              NZCOUNT;
    logic                    BLKDONE;

    modport master (
        output ENABLE, DCCI, INTRA, QP, YNIN,
        input  VALID, DCCO, ZOUT, NZCOUNT, BLKDONE
    );

    modport slave (
        input  ENABLE, DCCI, INTRA, QP, YNIN,
        output VALID, DCCO, ZOUT, NZCOUNT, BLKDONE
    );

endinterface

// File: rtl/h264_quantize_param.sv
// ---------------------------------------------------------------------------
// h264_quantize_param
//
// H.264 4x4 forward quantiser with per-sample QP and rounding mode.
// |Z| = (|Y| * factor + f) >> qbits, sign taken from Y, magnitude saturated
// symmetrically to 2^(OUT_W-1)-1. Fixed 4-cycle latency, one sample per
// cycle, no stalls. Also counts the non-zero AC levels of each 16-sample
// block and reports them with a BLKDONE pulse on the block's last level.
//
//   CLK   clock, all state on the rising edge
//   RSTN  asynchronous active-low reset
//   bus   slave side of h264_quantize_param_if (sample in, level out)
//
//   Pipeline: s1 operand select, s2 multiply, s3 round + shift,
//             s4 saturate + sign, then the output register.
// ---------------------------------------------------------------------------
module h264_quantize_param #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 12,
    parameter int QMF_W = 14
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    h264_quantize_param_if.slave   bus
);

    localparam int PROD_W = IN_W + QMF_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int F_W    = 25;           // floor(2^24/3) needs 23 bits
    localparam logic [SUM_W-1:0] ZMAX = SUM_W'((1 << (OUT_W - 1)) - 1);

    typedef enum logic [1:0] {FAC_A, FAC_B, FAC_C} fac_sel_e;

    // Multiplier factor tables, indexed by QP mod 6.
    function automatic logic [QMF_W-1:0] factor_lut(input fac_sel_e sel,
                                                    input logic [2:0] m);
        int v;
        v = 0;
        case (sel)
            FAC_A: case (m)
                3'd0: v = 13107;  3'd1: v = 11916;  3'd2: v = 10082;
                3'd3: v = 9362;   3'd4: v = 8192;   3'd5: v = 7282;
                default: v = 0;
            endcase
            FAC_B: case (m)
                3'd0: v = 5243;   3'd1: v = 4660;   3'd2: v = 4194;
                3'd3: v = 3647;   3'd4: v = 3355;   3'd5: v = 2893;
                default: v = 0;
            endcase
            default: case (m)
                3'd0: v = 8066;   3'd1: v = 7490;   3'd2: v = 6554;
                3'd3: v = 5825;   3'd4: v = 5243;   3'd5: v = 4559;
                default: v = 0;
            endcase
        endcase
        return QMF_W'(v);
    endfunction

    // Rounding offset floor(2^qbits/3) (intra) or floor(2^qbits/6) (inter),
    // tabulated so no divider is needed.
    function automatic logic [F_W-1:0] round_lut(input logic intra,
                                                 input logic [4:0] qbits);
        int v;
        v = 0;
        case (qbits)
            5'd15: v = intra ? 10922   : 5461;
            5'd16: v = intra ? 21845   : 10922;
            5'd17: v = intra ? 43690   : 21845;
            5'd18: v = intra ? 87381   : 43690;
            5'd19: v = intra ? 174762  : 87381;
            5'd20: v = intra ? 349525  : 174762;
            5'd21: v = intra ? 699050  : 349525;
            5'd22: v = intra ? 1398101 : 699050;
            5'd23: v = intra ? 2796202 : 1398101;
            5'd24: v = intra ? 5592405 : 2796202;
            default: v = 0;
        endcase
        return F_W'(v);
    endfunction

    // ---------------- input side (combinational) ----------------
    logic [3:0]      pos;
    logic [3:0]      qp_e;
    logic [2:0]      qp_m;
    fac_sel_e        sel0;
    logic [4:0]      qbits0;
    logic [IN_W-1:0] y_u;
    logic [IN_W-1:0] abs0;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        qp_e   = 4'(bus.QP / 6'd6);
        qp_m   = 3'(bus.QP % 6'd6);
        sel0   = FAC_C;
        if (bus.DCCI) begin
            sel0 = FAC_A;
        end else begin
            case (pos)
                4'd0, 4'd3, 4'd5, 4'd11:   sel0 = FAC_A;
                4'd4, 4'd10, 4'd12, 4'd15: sel0 = FAC_B;
                default:                   sel0 = FAC_C;
            endcase
        end
        // DC levels use one extra bit of shift.
        qbits0 = 5'd15 + 5'(qp_e) + 5'(bus.DCCI);
        y_u    = bus.YNIN;
        // |-2^(IN_W-1)| = 2^(IN_W-1) still fits IN_W unsigned bits.
        abs0   = y_u[IN_W-1] ? (~y_u + 1'b1) : y_u;
    end

    // ---------------- pipeline registers ----------------
    logic                    s1_valid, s2_valid, s3_valid, s4_valid;
    logic                    s1_dc, s2_dc, s3_dc, s4_dc;
    logic                    s1_first, s2_first, s3_first, s4_first;
    logic                    s1_last, s2_last, s3_last, s4_last;
    logic                    s1_neg, s2_neg, s3_neg;
    logic [IN_W-1:0]         s1_abs;
    logic [QMF_W-1:0]        s1_fac;
    logic [F_W-1:0]          s1_f, s2_f;
    logic [4:0]              s1_qbits, s2_qbits;
    logic [PROD_W-1:0]       s2_prod;
    logic [SUM_W-1:0]        s3_mag;
    logic signed [OUT_W-1:0] s4_z;
    logic                    s4_nz;

    logic [SUM_W-1:0]        sum3;
    logic [SUM_W-1:0]        mag_sat;
    logic [OUT_W-1:0]        z_mag;

    always_comb begin
        sum3    = SUM_W'(s2_prod) + SUM_W'(s2_f);
        mag_sat = (s3_mag > ZMAX) ? ZMAX : s3_mag;
        z_mag   = mag_sat[OUT_W-1:0];
    end

    // NOTE: datapath registers carry no reset; their contents are only
    // observed when the matching valid bit, which is reset, is set.
    always_ff @(posedge CLK) begin
        s1_dc    <= bus.DCCI;
        s1_first <= !bus.DCCI && (pos == 4'd15);
        s1_last  <= !bus.DCCI && (pos == 4'd0);
        s1_neg   <= bus.YNIN[IN_W-1];
        s1_abs   <= abs0;
        s1_fac   <= factor_lut(sel0, qp_m);
        s1_f     <= round_lut(bus.INTRA, qbits0);
        s1_qbits <= qbits0;

        s2_dc    <= s1_dc;
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_neg   <= s1_neg;
        s2_prod  <= PROD_W'(s1_abs) * PROD_W'(s1_fac);
        s2_f     <= s1_f;
        s2_qbits <= s1_qbits;

        s3_dc    <= s2_dc;
        s3_first <= s2_first;
        s3_last  <= s2_last;
        s3_neg   <= s2_neg;
        s3_mag   <= sum3 >> s2_qbits;

        s4_dc    <= s3_dc;
        s4_first <= s3_first;
        s4_last  <= s3_last;
        // Negating a zero magnitude yields zero, so -0 never appears.
        s4_z     <= s3_neg ? (~z_mag + 1'b1) : z_mag;
        s4_nz    <= (z_mag != '0);
    end

    // ---------------- control and output registers ----------------
    logic                    valid_q, dcco_q, blk_q;
    logic signed [OUT_W-1:0] zout_q;
    logic [4:0]              nzcount_q, nz_acc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pos       <= 4'd15;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            s4_valid  <= 1'b0;
            valid_q   <= 1'b0;
            dcco_q    <= 1'b0;
            blk_q     <= 1'b0;
            zout_q    <= '0;
            nzcount_q <= '0;
            nz_acc    <= '0;
        end else begin
            // Dropping ENABLE or a DC sample restarts the block scan.
            if (!bus.ENABLE || bus.DCCI) pos <= 4'd15;
            else                         pos <= pos - 4'd1;

            s1_valid <= bus.ENABLE;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s4_valid <= s3_valid;

            valid_q <= s4_valid;
            blk_q   <= s4_valid && !s4_dc && s4_last;
            if (s4_valid) begin
                zout_q <= s4_z;
                dcco_q <= s4_dc;
            end

            // An abandoned block never delivers its POS=0 level, so it is
            // simply overwritten by the next block's first level.
            if (s4_valid && !s4_dc) begin
                if (s4_first) nz_acc <= 5'(s4_nz);
                else          nz_acc <= nz_acc + 5'(s4_nz);
                if (s4_last)  nzcount_q <= nz_acc + 5'(s4_nz);
            end
        end
    end

    assign bus.VALID   = valid_q;
    assign bus.DCCO    = dcco_q;
    assign bus.ZOUT    = zout_q;
    assign bus.NZCOUNT = nzcount_q;
    assign bus.BLKDONE = blk_q;

endmodule

// File: tb/tb_h264_quantize_param.sv
// ---------------------------------------------------------------------------
// tb_h264_quantize_param
//
// Directed vectors for h264_quantize_param with hand-computed levels.
// Each stream of samples is driven contiguously on falling edges; the output
// of sample k is checked five falling edges later (accepted at rising edge
// k, visible after rising edge k+4). Cycles with no expected level check
// that VALID/BLKDONE are low and ZOUT/DCCO hold.
// ---------------------------------------------------------------------------
module tb_h264_quantize_param;

    localparam int IN_W  = 16;
    localparam int OUT_W = 12;
    localparam int QMF_W = 14;
    localparam int MAXV  = 20;

    logic CLK = 1'b0;
    logic RSTN;

    always #5 CLK = ~CLK;

    h264_quantize_param_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    h264_quantize_param #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .QMF_W (QMF_W)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus / expectation table for one stream.
    logic                   v_dc    [MAXV];
    logic                   v_intra [MAXV];
    logic [5:0]             v_qp    [MAXV];
    logic signed [IN_W-1:0] v_y     [MAXV];
    int                     v_z     [MAXV];
    logic                   v_blk   [MAXV];
    int                     v_nz    [MAXV];
    int                     n_v = 0;

    int   last_z  = 0;
    logic last_dc = 1'b0;

    task automatic add(input logic dc, input logic intra, input int qp,
                       input int y, input int z);
        v_dc[n_v]    = dc;
        v_intra[n_v] = intra;
        v_qp[n_v]    = 6'(qp);
        v_y[n_v]     = IN_W'(y);
        v_z[n_v]     = z;
        v_blk[n_v]   = 1'b0;
        v_nz[n_v]    = 0;
        n_v++;
    endtask

    task automatic drive_idle();
        bus.ENABLE = 1'b0;
        bus.DCCI   = 1'b0;
        bus.INTRA  = 1'b0;
        bus.QP     = 6'd0;
        bus.YNIN   = '0;
    endtask

    task automatic run_stream(input string tag);
        for (int j = 0; j < n_v + 6; j++) begin
            @(negedge CLK);
            if (j >= 5 && j - 5 < n_v) begin
                int k;
                k = j - 5;
                check($sformatf("%s[%0d] valid", tag, k), bus.VALID, 1);
                check($sformatf("%s[%0d] zout", tag, k), bus.ZOUT, v_z[k]);
                check($sformatf("%s[%0d] dcco", tag, k), bus.DCCO, v_dc[k]);
                check($sformatf("%s[%0d] blkdone", tag, k), bus.BLKDONE, v_blk[k]);
                if (v_blk[k])
                    check($sformatf("%s[%0d] nzcount", tag, k), bus.NZCOUNT, v_nz[k]);
                last_z  = v_z[k];
                last_dc = v_dc[k];
            end else begin
                check($sformatf("%s c%0d idle valid", tag, j), bus.VALID, 0);
                check($sformatf("%s c%0d idle blkdone", tag, j), bus.BLKDONE, 0);
                check($sformatf("%s c%0d hold zout", tag, j), bus.ZOUT, last_z);
                check($sformatf("%s c%0d hold dcco", tag, j), bus.DCCO, last_dc);
            end
            if (j < n_v) begin
                bus.ENABLE = 1'b1;
                bus.DCCI   = v_dc[j];
                bus.INTRA  = v_intra[j];
                bus.QP     = v_qp[j];
                bus.YNIN   = v_y[j];
            end else begin
                drive_idle();
            end
        end
        n_v = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " valid"},   bus.VALID,   0);
        check({tag, " dcco"},    bus.DCCO,    0);
        check({tag, " zout"},    bus.ZOUT,    0);
        check({tag, " blkdone"}, bus.BLKDONE, 0);
        check({tag, " nzcount"}, bus.NZCOUNT, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        RSTN = 1'b1;
        #3 RSTN = 1'b0;
        @(negedge CLK);
        check_reset_state("reset");
        @(negedge CLK);
        RSTN = 1'b1;

        // QP=0, POS=15 uses table B (5243), qbits 15, f 10922 / 5461.
        add(0, 1, 0, 5, 1);         run_stream("y5_intra");
        add(0, 0, 0, 5, 0);         run_stream("y5_inter");
        add(0, 1, 0, -5, -1);       run_stream("ym5_intra");
        add(0, 1, 0, 32767, 2047);  run_stream("sat_pos");
        add(0, 1, 0, -32768, -2047); run_stream("sat_neg");
        // QP=51: m=3, e=8, B=3647, qbits 23.
        add(0, 1, 51, 32767, 14);   run_stream("qp51");

        // DC: A=13107, qbits 16, f 21845 -> 2. Then AC at POS 15 (B) and 14 (C).
        add(1, 1, 0, 10, 2);
        add(0, 1, 0, 100, 16);
        add(0, 1, 0, 100, 24);
        run_stream("dc_then_ac");

        // QP/INTRA change travels with the sample: QP6 inter, C, qbits 16.
        add(0, 1, 0, 100, 16);
        add(0, 0, 6, 100, 12);
        run_stream("qp_change");

        // Full block: POS15 B -> 16, POS13 C -> -24, POS0 A -> 40, rest 0.
        for (int k = 0; k < 16; k++) begin
            if (k == 0)       add(0, 1, 0, 100, 16);
            else if (k == 2)  add(0, 1, 0, -100, -24);
            else if (k == 15) add(0, 1, 0, 100, 40);
            else              add(0, 1, 0, 1, 0);
        end
        v_blk[15] = 1'b1;
        v_nz[15]  = 3;
        run_stream("block");

        // Abandoned after 8 samples: no BLKDONE, NZCOUNT keeps 3.
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      add(0, 1, 0, 100, 16);
            else if (k == 7) add(0, 1, 0, 100, 24);
            else             add(0, 1, 0, 1, 0);
        end
        run_stream("abandon");
        check("abandon nzcount hold", bus.NZCOUNT, 3);

        // Reset with two samples in flight.
        @(negedge CLK);
        bus.ENABLE = 1'b1; bus.INTRA = 1'b1; bus.QP = 6'd0; bus.YNIN = 16'sd100;
        @(negedge CLK);
        @(negedge CLK);
        drive_idle();
        @(posedge CLK);
        #2 RSTN = 1'b0;
        #1 check_reset_state("midreset");
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        last_z  = 0;
        last_dc = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            check($sformatf("flush c%0d valid", c), bus.VALID, 0);
            check($sformatf("flush c%0d zout", c), bus.ZOUT, 0);
        end
        add(0, 1, 0, 5, 1);
        run_stream("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
